// File: rtl/eth_rx_frame_buffer_ctrl.sv
// Store-and-forward receive buffer: frames are written speculatively, committed or
// rolled back at tlast, and only committed frames are replayed on the master stream.
module eth_rx_frame_buffer_ctrl #(
   parameter int ADDR_WIDTH    = 11,
   parameter int MIN_FRAME_LEN = 60,
   parameter int MAX_FRAME_LEN = 1514
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   input  logic        rx_enable,
   input  logic        stats_clear,
   output logic [15:0] cnt_frames_ok,
   output logic [15:0] cnt_frames_err,
   output logic [15:0] cnt_frames_ovf,
   output logic        buf_empty
);

   // state  | meaning
   // W_IDLE | between frames, next valid beat is a frame start
   // W_RECV | writing an admitted frame into the buffer
   // W_DROP | discarding the rest of a rejected frame until tlast
   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_RECV = 2'd1;
   localparam logic [1:0] W_DROP = 2'd2;

   localparam int PW = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PW-1:0] FULL_USED = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
   localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

   logic [8:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
   logic [PW-1:0] wr_ptr_nxt, commit_ptr_nxt, used;
   logic [15:0]   len, len_nxt;
   logic [1:0]    w_state, w_state_nxt;
   logic          full, we, eof, inc_ok, inc_err, inc_ovf, rd_load;

   assign used = wr_ptr - rd_ptr;
   assign full = (used == FULL_USED);

   always_comb begin
      w_state_nxt    = w_state;
      wr_ptr_nxt     = wr_ptr;
      commit_ptr_nxt = commit_ptr;
      len_nxt        = len;
      we             = 1'b0;
      eof            = 1'b0;
      inc_ok         = 1'b0;
      inc_err        = 1'b0;
      inc_ovf        = 1'b0;
      if (s_axis_tvalid) begin
         case (w_state)
            W_IDLE: begin
               if (!rx_enable) begin
                  w_state_nxt = s_axis_tlast ? W_IDLE : W_DROP;
               end else if (full) begin
                  // buffer entirely held by committed data: never overwrite it
                  inc_ovf     = 1'b1;
                  w_state_nxt = s_axis_tlast ? W_IDLE : W_DROP;
               end else begin
                  we          = 1'b1;
                  len_nxt     = 16'd1;
                  w_state_nxt = W_RECV;
                  eof         = s_axis_tlast;
               end
            end
            W_RECV: begin
               if (full) begin
                  wr_ptr_nxt  = commit_ptr;
                  inc_ovf     = 1'b1;
                  w_state_nxt = s_axis_tlast ? W_IDLE : W_DROP;
               end else if (len == MAX_LEN && !s_axis_tlast) begin
                  wr_ptr_nxt  = commit_ptr;
                  inc_err     = 1'b1;
                  w_state_nxt = W_DROP;
               end else begin
                  we      = 1'b1;
                  len_nxt = len + 16'd1;
                  eof     = s_axis_tlast;
               end
            end
            W_DROP: begin
               if (s_axis_tlast) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
         endcase
      end
      if (we) wr_ptr_nxt = wr_ptr + 1'b1;
      if (eof) begin
         w_state_nxt = W_IDLE;
         // a tlast landing one past the maximum is still a giant
         if (s_axis_tuser || len_nxt < MIN_LEN || len_nxt > MAX_LEN) begin
            wr_ptr_nxt = commit_ptr;
            inc_err    = 1'b1;
         end else begin
            commit_ptr_nxt = wr_ptr + 1'b1;
            inc_ok         = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state    <= W_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         len        <= '0;
      end else begin
         w_state    <= w_state_nxt;
         wr_ptr     <= wr_ptr_nxt;
         commit_ptr <= commit_ptr_nxt;
         len        <= len_nxt;
      end
   end

   assign rd_load = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr        <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
      end else if (rd_load) begin
         {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
         m_axis_tvalid <= 1'b1;
         rd_ptr        <= rd_ptr + 1'b1;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   assign buf_empty = (rd_ptr == commit_ptr) && !m_axis_tvalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_frames_ok  <= '0;
         cnt_frames_err <= '0;
         cnt_frames_ovf <= '0;
      end else if (stats_clear) begin
         cnt_frames_ok  <= '0;
         cnt_frames_err <= '0;
         cnt_frames_ovf <= '0;
      end else begin
         if (inc_ok  && cnt_frames_ok  != 16'hFFFF) cnt_frames_ok  <= cnt_frames_ok  + 16'd1;
         if (inc_err && cnt_frames_err != 16'hFFFF) cnt_frames_err <= cnt_frames_err + 16'd1;
         if (inc_ovf && cnt_frames_ovf != 16'hFFFF) cnt_frames_ovf <= cnt_frames_ovf + 16'd1;
      end
   end

endmodule
